amem_ctl: RTL and testbench

Access controller for the 1024×32 A-memory. Shares the single A-memory address port between the microcode datapath (CPU port, absolute priority) and a debug/spy port that loads and inspects A-memory through a req/ack handshake. After every debug read the controller restores the A-memory read register to the CPU's last read address, so the CPU never sees debug data on `amem`. Sits between the CPU's A-address/L-bus logic and the A-memory instance.

---
 rtl/amem_ctl_pkg.sv | 7 +
 rtl/amem_clear_seq.sv | 29 ++
 rtl/amem_ctl.sv | 113 +++++++++++
 tb/tb_amem_ctl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/amem_ctl_pkg.sv
// amem_ctl_pkg: shared types and constants for the A-memory access controller
package amem_ctl_pkg;
    localparam int AMEM_ADDR_WIDTH = 10;
    localparam int AMEM_DATA_WIDTH = 32;
    localparam int AMEM_DEPTH = 1024;
    typedef enum logic [1:0] {IDLE, CAP, DONE, CLEAR} amem_ctl_state_t;
endpackage

// File: rtl/amem_clear_seq.sv
// amem_clear_seq: post-reset zero-fill sweep over the whole A-memory
// Present only when AMEM_CLEAR_EN is defined.
// Ports: clk, reset (sync, active-high); cnt = address being written,
// busy = sweep in progress (1 from reset through the last address), awp = write strobe.
`ifdef AMEM_CLEAR_EN
module amem_clear_seq
    import amem_ctl_pkg::*;
#(
    parameter int ADDR_WIDTH = AMEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] cnt,
    output logic                  busy,
    output logic                  awp
);
    // busy drops after the all-ones address, so the counter's wrap to 0 issues nothing
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            cnt  <= cnt + 1'b1;
            busy <= ~&cnt;
        end
    end
    assign awp = busy;
endmodule
`endif

// File: rtl/amem_ctl.sv
// amem_ctl: arbitrates the A-memory port between the CPU (absolute priority) and a debug req/ack port
// Ports: clk, reset (sync, active-high);
//   cpu_aadr/cpu_arp/cpu_awp/cpu_l : CPU access, passed through combinationally
//   dbg_req/dbg_we/dbg_addr/dbg_wdata -> dbg_ack/dbg_rdata : debug handshake
//   aadr/arp/awp/l -> A-memory, amem <- A-memory registered read data
//   clr_busy : zero-fill sweep in progress
// Macro AMEM_CLEAR_EN: zero-fill the memory after reset (CLEAR state); otherwise clr_busy is 0.
module amem_ctl
    import amem_ctl_pkg::*;
#(
    parameter int ADDR_WIDTH = AMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = AMEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_aadr,
    input  logic                  cpu_arp,
    input  logic                  cpu_awp,
    input  logic [DATA_WIDTH-1:0] cpu_l,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic [ADDR_WIDTH-1:0] aadr,
    output logic                  arp,
    output logic                  awp,
    output logic [DATA_WIDTH-1:0] l,
    input  logic [DATA_WIDTH-1:0] amem,
    output logic                  clr_busy
);
    amem_ctl_state_t       state, state_nxt;
    logic                  restore_pend;
    logic [ADDR_WIDTH-1:0] last_cpu_addr;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_awp, clr_last;
    logic                  clearing, cpu_act, accept, restore;
`ifdef AMEM_CLEAR_EN
    localparam amem_ctl_state_t RESET_STATE = CLEAR;
    amem_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear (
        .clk  (clk),
        .reset(reset),
        .cnt  (clr_addr),
        .busy (clr_busy),
        .awp  (clr_awp)
    );
    assign clr_last = &clr_addr;
`else
    localparam amem_ctl_state_t RESET_STATE = IDLE;
    assign clr_addr = '0;
    assign clr_awp  = 1'b0;
    assign clr_last = 1'b0;
    assign clr_busy = 1'b0;
`endif
    assign clearing = state == CLEAR;
    // CPU strobes are dropped while the sweep owns the port
    assign cpu_act  = (cpu_arp | cpu_awp) & ~clearing;
    assign accept   = state == IDLE & dbg_req & ~cpu_act & ~restore_pend;
    // the CAP cycle may already restore: the debug data is in amem and gets captured this cycle
    assign restore  = (restore_pend | state == CAP) & ~cpu_act;
    always_ff @(posedge clk) begin
        if (reset) state <= RESET_STATE;
        else       state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = accept ? (dbg_we ? DONE : CAP) : IDLE;
            CAP:   state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            CLEAR: state_nxt = clr_last ? IDLE : CLEAR;
        endcase
    end
    always_comb begin
        aadr = '0;
        arp  = 1'b0;
        awp  = 1'b0;
        l    = '0;
        if (!reset) begin
            if (clearing) begin
                aadr = clr_addr;
                awp  = clr_awp;
            end else if (cpu_act) begin
                aadr = cpu_aadr;
                arp  = cpu_arp;
                awp  = cpu_awp;
                l    = cpu_l;
            end else if (restore) begin
                aadr = last_cpu_addr;
                arp  = 1'b1;
            end else if (accept) begin
                aadr = dbg_addr;
                arp  = ~dbg_we;
                awp  = dbg_we;
                l    = dbg_wdata;
            end
        end
    end
    assign dbg_ack = state == DONE & ~reset;
    // a CPU read makes any pending restore moot; a CPU write-only cycle just defers it
    always_ff @(posedge clk) begin
        if (reset) begin
            restore_pend  <= 1'b0;
            last_cpu_addr <= '0;
            dbg_rdata     <= '0;
        end else begin
            if (cpu_act && cpu_arp) last_cpu_addr <= cpu_aadr;
            if (state == CAP) dbg_rdata <= amem;
            restore_pend <= ((cpu_act && cpu_arp) || restore) ? 1'b0 : (restore_pend | state == CAP);
        end
    end
endmodule

// File: tb/tb_amem_ctl.sv
// tb_amem_ctl: directed self-checking bench for amem_ctl with a registered-read A-memory model
module tb_amem_ctl;
    import amem_ctl_pkg::*;
`ifdef AMEM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b1;
    logic [9:0]  cpu_aadr = '0, dbg_addr = '0, aadr;
    logic        cpu_arp = 1'b0, cpu_awp = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] cpu_l = '0, dbg_wdata = '0, dbg_rdata, l, amem;
    logic        dbg_ack, arp, awp, clr_busy;
    logic [31:0] mem [0:AMEM_DEPTH-1];
    int checks = 0, errors = 0;

    amem_ctl dut (
        .clk(clk), .reset(reset), .cpu_aadr(cpu_aadr), .cpu_arp(cpu_arp), .cpu_awp(cpu_awp),
        .cpu_l(cpu_l), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .aadr(aadr),
        .arp(arp), .awp(awp), .l(l), .amem(amem), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (arp) amem <= mem[aadr];
        if (awp) mem[aadr] <= l;
    end

    initial begin
        #1ms;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [31:0] d);
        cpu_aadr = a; cpu_l = d; cpu_awp = 1'b1;
        tick;
        cpu_awp = 1'b0;
    endtask

    task automatic cpu_read(input logic [9:0] a);
        cpu_aadr = a; cpu_arp = 1'b1;
        tick;
        cpu_arp = 1'b0;
    endtask

    // returns in the ack cycle; lat = cycles from request to ack, -1 if none came
    task automatic dbg_op(input logic we, input logic [9:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        bit got = 0;
        dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_req = 1'b1;
        lat = 0;
        while (!got && lat < 20) begin
            tick;
            lat++;
            if (dbg_ack === 1'b1) got = 1;
        end
        if (!got) lat = -1;
        rd = dbg_rdata;
        dbg_req = 1'b0;
    endtask

    task automatic wait_clear;
        int n = 0;
        while (clr_busy !== 1'b0 && n < 1100) begin tick; n++; end
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL clear_end got %0b exp 0", clr_busy); end
    endtask

    task automatic test_reset;
        tick; tick;
        checks++; if ({dbg_ack, arp, awp} !== 3'b000) begin errors++; $display("FAIL rst_strobes got %b exp 000", {dbg_ack, arp, awp}); end
        checks++; if ({aadr, l, dbg_rdata} !== 74'd0) begin errors++; $display("FAIL rst_data got %h %h %h exp 0", aadr, l, dbg_rdata); end
        checks++; if (clr_busy !== CLR) begin errors++; $display("FAIL rst_clr_busy got %0b exp %0b", clr_busy, CLR); end
        reset = 1'b0;
        if (CLR) wait_clear;
        tick;
        checks++; if ({dbg_ack, arp, awp} !== 3'b000) begin errors++; $display("FAIL idle_strobes got %b exp 000", {dbg_ack, arp, awp}); end
    endtask

    task automatic test_dbg_write_read;
        dbg_we = 1'b1; dbg_addr = 10'h3FF; dbg_wdata = 32'hDEADBEEF; dbg_req = 1'b1;
        #1;
        checks++; if ({awp, arp, aadr, l} !== {2'b10, 10'h3FF, 32'hDEADBEEF}) begin errors++; $display("FAIL wr_issue got %b%b %h %h exp 10 3ff deadbeef", awp, arp, aadr, l); end
        tick;
        checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %0b exp 1", dbg_ack); end
        tick;
        dbg_we = 1'b0;
        #1;
        checks++; if ({awp, arp, aadr} !== {2'b01, 10'h3FF}) begin errors++; $display("FAIL rd_issue got %b%b %h exp 01 3ff", awp, arp, aadr); end
        tick;
        checks++; if ({dbg_ack, arp, aadr} !== {2'b01, 10'h000}) begin errors++; $display("FAIL rd_cap got ack %0b arp %0b aadr %h exp 0 1 000", dbg_ack, arp, aadr); end
        tick;
        checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL rd_ack got %0b exp 1", dbg_ack); end
        checks++; if (dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", dbg_rdata); end
        dbg_req = 1'b0;
        tick;
        checks++; if ({dbg_ack, arp, awp} !== 3'b000) begin errors++; $display("FAIL rd_after got %b exp 000", {dbg_ack, arp, awp}); end
    endtask

    task automatic test_cpu_priority;
        logic [31:0] rd;
        int lat;
        cpu_aadr = 10'h010; cpu_l = 32'hAAAA0010; cpu_awp = 1'b1;
        dbg_we = 1'b1; dbg_addr = 10'h020; dbg_wdata = 32'hBBBB0020; dbg_req = 1'b1;
        #1;
        checks++; if ({awp, arp, aadr, l} !== {2'b10, 10'h010, 32'hAAAA0010}) begin errors++; $display("FAIL prio_cpu got %b%b %h %h exp 10 010 aaaa0010", awp, arp, aadr, l); end
        tick;
        cpu_awp = 1'b0;
        #1;
        checks++; if ({awp, aadr, l, dbg_ack} !== {1'b1, 10'h020, 32'hBBBB0020, 1'b0}) begin errors++; $display("FAIL prio_dbg got %b %h %h ack %b exp 1 020 bbbb0020 0", awp, aadr, l, dbg_ack); end
        tick;
        checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL prio_ack got %0b exp 1", dbg_ack); end
        dbg_req = 1'b0;
        tick;
        cpu_read(10'h010);
        checks++; if (amem !== 32'hAAAA0010) begin errors++; $display("FAIL prio_mem_cpu got %h exp aaaa0010", amem); end
        dbg_op(1'b0, 10'h020, 32'h0, rd, lat);
        checks++; if (rd !== 32'hBBBB0020 || lat != 2) begin errors++; $display("FAIL prio_mem_dbg got %h lat %0d exp bbbb0020 lat 2", rd, lat); end
        tick;
    endtask

    task automatic test_restore;
        cpu_write(10'h005, 32'h11111111);
        cpu_write(10'h006, 32'h22222222);
        cpu_aadr = 10'h005; cpu_arp = 1'b1;
        tick;
        cpu_arp = 1'b0;
        dbg_we = 1'b0; dbg_addr = 10'h006; dbg_req = 1'b1;
        #1;
        checks++; if (amem !== 32'h11111111) begin errors++; $display("FAIL rs_cpu_data got %h exp 11111111", amem); end
        checks++; if ({arp, aadr} !== {1'b1, 10'h006}) begin errors++; $display("FAIL rs_issue got %b %h exp 1 006", arp, aadr); end
        tick;
        checks++; if ({arp, aadr, amem} !== {1'b1, 10'h005, 32'h22222222}) begin errors++; $display("FAIL rs_cap got %b %h %h exp 1 005 22222222", arp, aadr, amem); end
        tick;
        checks++; if ({dbg_ack, dbg_rdata} !== {1'b1, 32'h22222222}) begin errors++; $display("FAIL rs_ack got %b %h exp 1 22222222", dbg_ack, dbg_rdata); end
        checks++; if (amem !== 32'h11111111) begin errors++; $display("FAIL rs_restored got %h exp 11111111", amem); end
        dbg_req = 1'b0;
        tick;
    endtask

    task automatic test_restore_defer;
        logic [31:0] rd;
        int lat;
        dbg_we = 1'b0; dbg_addr = 10'h006; dbg_req = 1'b1;
        tick;
        cpu_aadr = 10'h030; cpu_l = 32'h33333333; cpu_awp = 1'b1;
        #1;
        checks++; if ({awp, arp, aadr} !== {2'b10, 10'h030}) begin errors++; $display("FAIL df_cap got %b%b %h exp 10 030", awp, arp, aadr); end
        tick;
        cpu_aadr = 10'h031; cpu_l = 32'h34343434;
        #1;
        checks++; if ({dbg_ack, arp, aadr, dbg_rdata} !== {2'b10, 10'h031, 32'h22222222}) begin errors++; $display("FAIL df_done got ack %b arp %b %h %h exp 1 0 031 22222222", dbg_ack, arp, aadr, dbg_rdata); end
        dbg_req = 1'b0;
        tick;
        cpu_awp = 1'b0;
        dbg_we = 1'b1; dbg_addr = 10'h040; dbg_wdata = 32'h44444444; dbg_req = 1'b1;
        #1;
        checks++; if ({arp, awp, aadr} !== {2'b10, 10'h005}) begin errors++; $display("FAIL df_restore got %b%b %h exp 10 005", arp, awp, aadr); end
        tick;
        checks++; if ({arp, awp, aadr, l} !== {2'b01, 10'h040, 32'h44444444}) begin errors++; $display("FAIL df_accept got %b%b %h %h exp 01 040 44444444", arp, awp, aadr, l); end
        tick;
        checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL df_ack got %0b exp 1", dbg_ack); end
        checks++; if (amem !== 32'h11111111) begin errors++; $display("FAIL df_amem got %h exp 11111111", amem); end
        dbg_req = 1'b0;
        tick;
        cpu_read(10'h030);
        checks++; if (amem !== 32'h33333333) begin errors++; $display("FAIL df_cpuwr got %h exp 33333333", amem); end
        dbg_op(1'b0, 10'h040, 32'h0, rd, lat);
        checks++; if (rd !== 32'h44444444 || lat != 2) begin errors++; $display("FAIL df_dbgwr got %h lat %0d exp 44444444 lat 2", rd, lat); end
        tick;
    endtask

    task automatic test_write_last_addr;
        logic [31:0] rd;
        int lat;
        cpu_read(10'h005);
        dbg_op(1'b1, 10'h005, 32'h55555555, rd, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL wl_wr_lat got %0d exp 1", lat); end
        tick;
        dbg_op(1'b0, 10'h006, 32'h0, rd, lat);
        checks++; if (rd !== 32'h22222222 || lat != 2) begin errors++; $display("FAIL wl_rd got %h lat %0d exp 22222222 lat 2", rd, lat); end
        checks++; if (amem !== 32'h55555555) begin errors++; $display("FAIL wl_restore got %h exp 55555555", amem); end
        tick;
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        int lat;
        dbg_we = 1'b0; dbg_addr = 10'h3FF; dbg_req = 1'b1;
        tick;
        reset = 1'b1;
        #1;
        checks++; if ({arp, awp} !== 2'b00) begin errors++; $display("FAIL rm_gated got %b exp 00", {arp, awp}); end
        tick;
        reset = 1'b0; dbg_req = 1'b0;
        #1;
        checks++; if ({dbg_ack, arp, awp, aadr, l, dbg_rdata} !== {2'b00, CLR, 74'd0}) begin errors++; $display("FAIL rm_outputs got %b%b%b %h %h %h exp 00%0b 0 0 0", dbg_ack, arp, awp, aadr, l, dbg_rdata, CLR); end
        tick;
        checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL rm_no_ack got %0b exp 0", dbg_ack); end
        if (CLR) wait_clear;
        tick;
        dbg_op(1'b0, 10'h3FF, 32'h0, rd, lat);
        checks++; if (rd !== (CLR ? 32'h0 : 32'hDEADBEEF) || lat != 2) begin errors++; $display("FAIL rm_recover got %h lat %0d", rd, lat); end
        tick;
    endtask

`ifdef AMEM_CLEAR_EN
    task automatic test_clear;
        int n = 0;
        cpu_write(10'h000, 32'hFFFFFFFF);
        cpu_write(10'h200, 32'hFFFFFFFF);
        cpu_write(10'h3FF, 32'hFFFFFFFF);
        cpu_read(10'h200);
        checks++; if (amem !== 32'hFFFFFFFF) begin errors++; $display("FAIL cl_preload got %h exp ffffffff", amem); end
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        while (clr_busy === 1'b1 && n < 2000) begin n++; tick; end
        checks++; if (n != 1024) begin errors++; $display("FAIL cl_busy_cycles got %0d exp 1024", n); end
        cpu_read(10'h000);
        checks++; if (amem !== 32'h0) begin errors++; $display("FAIL cl_000 got %h exp 0", amem); end
        cpu_read(10'h200);
        checks++; if (amem !== 32'h0) begin errors++; $display("FAIL cl_200 got %h exp 0", amem); end
        cpu_read(10'h3FF);
        checks++; if (amem !== 32'h0) begin errors++; $display("FAIL cl_3ff got %h exp 0", amem); end
    endtask
`endif

    initial begin
        test_reset;
        test_dbg_write_read;
        test_cpu_priority;
        test_restore;
        test_restore_defer;
        test_write_last_addr;
        test_reset_mid;
`ifdef AMEM_CLEAR_EN
        test_clear;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
